uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Round-robin scheduler that shares one UART serial transmit line between NREQ byte producers. It grants one requester per frame and sequences the 8N1 frame (start, 8 data LSB-first, stop) from an internal bit-period counter. This counter uses the same divide-by-count scheme as the existing baud generator, so no external rate strobe is needed. It sits between the producer logic and the `tx` pin.

## Interface
- `NREQ`, 2: number of requesters, 2..8.
- `CLKS_PER_BIT`, 5208: clock cycles per serial bit (50 MHz / 9600 baud). Must be ≥ 2.
- `clock` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input NREQ: requester i has a byte pending. Must hold with stable data until granted.
- `req_data` input NREQ*8: byte of requester i at bits [8i+7:8i].
- `req_ready` output NREQ: one-hot grant. The byte transfers on a clock edge where `req_valid[i] & req_ready[i]`.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high from the cycle after a grant through the last stop-bit cycle.
- `grant_id` output $clog2(NREQ) (min 1): index of the requester owning the current or most recent frame.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- **IDLE**
  - `tx`=1, `busy`=0.
  - `req_ready` is combinational: one-hot for the winner when any `req_valid` is high, else 0.
  - Winner is the first set `req_valid` at or after `rr_ptr`, searching upward with wrap.
  - On the transfer edge: capture `req_data` of the winner into `shreg`, set `grant_id`, set `rr_ptr` = (winner+1) mod NREQ, clear `bit_cnt`, go to START.
- **START**: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- **DATA**
  - `tx`=`shreg[0]`. After CLKS_PER_BIT cycles, shift right and increment the index.
  - After index 7 completes, go to STOP.
- **STOP**: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Bit counter `bit_cnt`:
  - Width $clog2(CLKS_PER_BIT), unsigned.
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at the terminal count. The terminal count advances the FSM.
  - Forced to 0 on grant, so bit timing is frame-aligned and independent of prior phase.
- `req_ready` is 0 in every state except IDLE. Requests arriving mid-frame wait.
- If `req_valid` drops before grant, no transfer occurs and the pointer is unchanged.
- Simultaneous requests: only the winner is granted. Losers keep `req_ready`=0 and hold.
- `req_data` of non-winners is ignored.
- A requester granted last has lowest priority next frame. With continuous requests from all requesters, grants rotate 0,1,…,NREQ-1,0.
- **Reset** (any time, including mid-frame), immediately and asynchronously:
  - state=IDLE, `tx`=1, `busy`=0, `grant_id`=0, `rr_ptr`=0, `bit_cnt`=0, `shreg`=0.
  - `req_ready` follows IDLE rules once reset is released.
  - The partial frame is abandoned and is not retransmitted.

## Timing
- Grant edge T: `tx` falls and `busy` rises in the cycle after T.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Start bit covers cycles T+1..T+CLKS_PER_BIT.
- IDLE is re-entered at cycle T+10*CLKS_PER_BIT+1. The next grant can occur on that cycle's edge.
  - Back-to-back frames therefore have one idle-high cycle between the stop bit and the next start bit.
  - Minimum frame-to-frame period: 10*CLKS_PER_BIT+1 cycles.
- `tx`, `busy`, `grant_id` are registered outputs. `req_ready` is combinational from registered state and `req_valid` only, with no path from `req_data`.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE/START/DATA/STOP),
  - `DATA_BITS`=8 and `FRAME_BITS`=10,
  - the default `CLKS_PER_BIT` constant shared with the baud generator.
- One sub-module, `rr_arbiter`, is combinational.
  - Inputs: `req` (NREQ), `ptr`.
  - Outputs: one-hot `grant`, encoded `grant_idx`, `any`.
- FSM, bit counter and shift register stay in `uart_tx_scheduler`.

## Test plan
All scenarios use CLKS_PER_BIT=4 and NREQ=2.
1. Reset, then requester 0 sends 0xA5:
   - `req_ready[0]` pulses for one cycle.
   - `tx` = 0, then 1,0,1,0,0,1,0,1, then 1, each level held 4 cycles (40 cycles total).
   - `busy` is high for exactly 40 cycles. `grant_id`=0.
2. Both requesters valid at the same cycle after reset (0x11, 0x22):
   - Requester 0 is granted first.
   - Requester 1 is granted 41 cycles later.
   - The line carries 0x11 then 0x22 with one idle cycle between frames.
3. Both requesters hold valid continuously for 4 frames: grant order is 0,1,0,1. `grant_id` tracks the order.
4. Requester 1 raises valid mid-frame of requester 0:
   - `req_ready[1]` stays 0 until IDLE.
   - Then it is granted, and its start bit begins exactly 1 cycle after IDLE entry.
5. Assert `reset` low during DATA bit 3:
   - `tx`=1 and `busy`=0 immediately, without waiting for a clock edge.
   - After release, a fresh request from requester 1 transmits a complete, correctly timed frame.
6. Requester drops `req_valid` while another frame is active:
   - No grant is issued to it.
   - `rr_ptr` is unaffected; the next grant follows round-robin from the last winner.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, transmit FSM states and the
// default bit period used by the baud generator and the transmit scheduler.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned FRAME_BITS           = 10;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 5208;  // 50 MHz / 9600 baud

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// after ptr, searching upward with wrap-around.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]            req,
    input  logic [idx_width(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]            grant,
    output logic [idx_width(NREQ)-1:0] grant_idx,
    output logic                       any
);

    localparam int unsigned IDX_W = idx_width(NREQ);

    logic [IDX_W-1:0] cand;

    // Scan candidates in rotated order; the first one requesting wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = IDX_W'((32'(ptr) + off) % NREQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1 UART transmit line among NREQ byte producers, granting one
// requester per frame in round-robin order and timing each bit internally.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*DATA_BITS-1:0]   req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [idx_width(NREQ)-1:0]  grant_id
);

    localparam int unsigned IDX_W  = idx_width(NREQ);
    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIDX_W = $clog2(DATA_BITS);

    tx_state_e             state, state_d;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_d;
    logic [BIDX_W-1:0]     bit_idx, bit_idx_d;
    logic [DATA_BITS-1:0]  shreg, shreg_d, win_data;
    logic [IDX_W-1:0]      rr_ptr, rr_ptr_d, grant_id_d, win_idx;
    logic [NREQ-1:0]       win_grant;
    logic                  win_any, tick, tx_d, busy_d;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (win_grant),
        .grant_idx (win_idx),
        .any       (win_any)
    );

    assign tick = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Select the winner's byte through the one-hot grant.
    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_grant[i]) begin
                win_data = win_data | req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: each terminal bit count advances the frame.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (win_any) state_d = START;
            START: if (tick) state_d = DATA;
            DATA:  if (tick && bit_idx == BIDX_W'(DATA_BITS - 1)) state_d = STOP;
            STOP:  if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: bit timer, bit index, shift register, pointer.
    always_comb begin
        bit_cnt_d  = tick ? '0 : bit_cnt + 1'b1;
        bit_idx_d  = bit_idx;
        shreg_d    = shreg;
        rr_ptr_d   = rr_ptr;
        grant_id_d = grant_id;
        case (state)
            IDLE: begin
                bit_cnt_d = '0;
                bit_idx_d = '0;
                if (win_any) begin
                    shreg_d    = win_data;
                    grant_id_d = win_idx;
                    rr_ptr_d   = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                end
            end
            START: if (tick) bit_idx_d = '0;
            DATA: begin
                if (tick) begin
                    shreg_d   = shreg >> 1;
                    bit_idx_d = bit_idx + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs: tx/busy are computed from next-cycle values so the registered
    // versions line up with the state they describe.
    always_comb begin
        req_ready = (state == IDLE) ? win_grant : '0;
        busy_d    = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rr_ptr   <= '0;
            grant_id <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            bit_cnt  <= bit_cnt_d;
            bit_idx  <= bit_idx_d;
            shreg    <= shreg_d;
            rr_ptr   <= rr_ptr_d;
            grant_id <= grant_id_d;
            tx       <= tx_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler with a frame-level reference
// model: each grant opens a 10-bit window whose line level is computed from
// the cycle offset into the frame.
module tb_uart_tx_scheduler;

    localparam int NREQ  = 2;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic             clock = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]  req_ready;
    logic             tx;
    logic             busy;
    logic [0:0]       grant_id;

    always #5 clock = ~clock;

    uart_tx_scheduler #(.NREQ(NREQ), .CLKS_PER_BIT(CPB)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         cyc = 0;
    bit         m_active;
    int         m_start;
    logic [7:0] m_byte;
    int         m_owner;
    int         m_ptr;
    bit         refill;
    bit         pend  [NREQ];
    logic [7:0] pdata [NREQ];
    int         busy_cnt;
    int         g_cyc [$];
    int         g_id  [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit m_idle();
        return !m_active || (cyc >= m_start + FRAME);
    endfunction

    function automatic int pick_winner();
        for (int off = 0; off < NREQ; off++) begin
            int idx;
            idx = (m_ptr + off) % NREQ;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_owner  = 0;
        m_ptr    = 0;
        refill   = 0;
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
    endtask

    // One clock cycle: drive inputs, check all outputs, then advance the model.
    task automatic cycle();
        int   w, k;
        logic etx, ebusy;
        logic [NREQ-1:0] erdy;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = pend[i];
            req_data[i*8 +: 8]  = pdata[i];
        end
        #1;
        if (!m_idle()) begin
            k     = (cyc - m_start) / CPB;
            ebusy = 1'b1;
            if (k == 0)      etx = 1'b0;
            else if (k == 9) etx = 1'b1;
            else             etx = m_byte[k-1];
        end else begin
            ebusy = 1'b0;
            etx   = 1'b1;
        end
        check_eq("tx", 32'(tx), 32'(etx));
        check_eq("busy", 32'(busy), 32'(ebusy));
        check_eq("grant_id", 32'(grant_id), 32'(m_owner));
        w    = m_idle() ? pick_winner() : -1;
        erdy = '0;
        if (w >= 0) erdy[w] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(erdy));
        if (busy) busy_cnt++;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] && req_valid[i]) begin
                g_cyc.push_back(cyc);
                g_id.push_back(i);
            end
        end
        @(posedge clock);
        if (w >= 0) begin
            m_active = 1;
            m_start  = cyc + 1;
            m_byte   = pdata[w];
            m_owner  = w;
            m_ptr    = (w + 1) % NREQ;
            pend[w]  = 0;
            if (refill) for (int i = 0; i < NREQ; i++) pend[i] = 1;
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Asynchronous reset: outputs must settle before any clock edge.
    task automatic apply_reset();
        #2;
        reset     = 1'b0;
        req_valid = '0;
        model_reset();
        #1;
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        g_cyc.delete();
        g_id.delete();
        busy_cnt = 0;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        model_reset();
        for (int i = 0; i < NREQ; i++) pdata[i] = 8'h00;
        @(negedge clock);
        apply_reset();

        // 1: single byte from requester 0
        pend[0] = 1; pdata[0] = 8'hA5;
        run(45);
        check_eq("s1_grants", 32'(g_cyc.size()), 32'd1);
        check_eq("s1_busy_cycles", 32'(busy_cnt), 32'd40);

        // 2: simultaneous requests
        apply_reset();
        pend[0] = 1; pdata[0] = 8'h11;
        pend[1] = 1; pdata[1] = 8'h22;
        run(90);
        check_eq("s2_grants", 32'(g_id.size()), 32'd2);
        if (g_id.size() >= 2) begin
            check_eq("s2_first", 32'(g_id[0]), 32'd0);
            check_eq("s2_second", 32'(g_id[1]), 32'd1);
            check_eq("s2_gap", 32'(g_cyc[1] - g_cyc[0]), 32'd41);
        end

        // 3: continuous requests rotate
        apply_reset();
        pdata[0] = 8'h5A; pdata[1] = 8'hC3;
        pend[0] = 1; pend[1] = 1; refill = 1;
        run(4 * (FRAME + 1));
        refill = 0;
        check_eq("s3_grants", 32'(g_id.size()), 32'd4);
        if (g_id.size() >= 4) begin
            for (int i = 0; i < 4; i++) check_eq("s3_order", 32'(g_id[i]), 32'(i % 2));
        end
        run(FRAME + 2);

        // 4: request arriving mid-frame waits for IDLE
        apply_reset();
        pend[0] = 1; pdata[0] = 8'h3E;
        run(10);
        pend[1] = 1; pdata[1] = 8'hB7;
        run(80);
        check_eq("s4_grants", 32'(g_id.size()), 32'd2);
        if (g_id.size() >= 2) begin
            check_eq("s4_second_id", 32'(g_id[1]), 32'd1);
            check_eq("s4_gap", 32'(g_cyc[1] - g_cyc[0]), 32'd41);
        end

        // 5: reset during data bit 3, then a fresh frame from requester 1
        apply_reset();
        pend[0] = 1; pdata[0] = 8'h3C;
        run(18);
        check_eq("s5_busy_before", 32'(busy), 32'd1);
        apply_reset();
        pend[1] = 1; pdata[1] = 8'h96;
        run(45);
        check_eq("s5_grants", 32'(g_id.size()), 32'd1);
        if (g_id.size() >= 1) check_eq("s5_id", 32'(g_id[0]), 32'd1);
        check_eq("s5_busy_cycles", 32'(busy_cnt), 32'd40);

        // 6: withdrawn request leaves the pointer alone
        apply_reset();
        pend[0] = 1; pdata[0] = 8'h81;
        run(5);
        pend[1] = 1; pdata[1] = 8'h7E;
        run(15);
        pend[1] = 0;
        run(10);
        pend[0] = 1; pdata[0] = 8'h42;
        run(20);
        pend[0] = 1; pdata[0] = 8'h24;
        pend[1] = 1; pdata[1] = 8'hE7;
        run(90);
        check_eq("s6_grants", 32'(g_id.size()), 32'd4);
        if (g_id.size() >= 3) begin
            check_eq("s6_g0", 32'(g_id[0]), 32'd0);
            check_eq("s6_g1", 32'(g_id[1]), 32'd0);
            check_eq("s6_g2", 32'(g_id[2]), 32'd1);
        end

        // Randomized traffic with occasional withdrawals while the line is busy
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 19) == 0) begin
                        pend[i]  = 1;
                        pdata[i] = 8'($urandom_range(0, 255));
                    end
                end else if (!m_idle() && $urandom_range(0, 199) == 0) begin
                    pend[i] = 0;
                end
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
